// File: rtl/turing_pkg.sv
// Shared encodings for the programmable Turing machine core:
// move codes, completion status, control FSM states and rule field offsets.
package turing_pkg;

    localparam logic [1:0] MOVE_STAY = 2'b00;
    localparam logic [1:0] MOVE_R    = 2'b01;
    localparam logic [1:0] MOVE_L    = 2'b10;

    localparam logic [1:0] ST_HALT    = 2'b00;
    localparam logic [1:0] ST_LEFT    = 2'b01;
    localparam logic [1:0] ST_RIGHT   = 2'b10;
    localparam logic [1:0] ST_TIMEOUT = 2'b11;

    // Rule entry layout: {next_state, write_bit, move[1:0], halt}
    localparam int RULE_HALT = 0;
    localparam int RULE_MOVE = 1;
    localparam int RULE_WBIT = 3;
    localparam int RULE_NEXT = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } fsm_t;

endpackage

// File: rtl/turing_rule_table.sv
// Rule register file: one write port with async clear, one combinational
// read port indexed by {state, read_symbol}.
module turing_rule_table
    import turing_pkg::*;
#(
    parameter int STATE_W = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic [STATE_W:0]   waddr,
    input  logic [STATE_W+3:0] wdata,
    input  logic [STATE_W:0]   raddr,
    output logic [STATE_W+3:0] rdata
);

    localparam int DEPTH = 2 ** (STATE_W + 1);

    logic [STATE_W+3:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/turing_engine.sv
// Single-tape binary Turing machine with a loadable rule table,
// start/busy/done handshake, edge-fault detection and step timeout.
module turing_engine
    import turing_pkg::*;
#(
    parameter int TAPE_LEN  = 16,
    parameter int STATE_W   = 2,
    parameter int MAX_STEPS = 255,
    parameter int HEAD_W    = $clog2(TAPE_LEN),
    parameter int STEP_W    = $clog2(MAX_STEPS + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rule_we,
    input  logic [STATE_W:0]    rule_addr,
    input  logic [STATE_W+3:0]  rule_data,
    input  logic                start,
    input  logic [TAPE_LEN-1:0] tape_in,
    input  logic [HEAD_W-1:0]   head_in,
    output logic                busy,
    output logic                done,
    output logic [1:0]          status,
    output logic [TAPE_LEN-1:0] tape_out,
    output logic [HEAD_W-1:0]   head_out,
    output logic [STATE_W-1:0]  state_out,
    output logic [STEP_W-1:0]   steps
);

    fsm_t fsm_q, fsm_d;

    logic [TAPE_LEN-1:0] tape_q;
    logic [HEAD_W-1:0]   head_q;
    logic [STATE_W-1:0]  state_q;
    logic [STEP_W-1:0]   steps_q;
    logic [1:0]          status_q;

    logic [STATE_W+3:0] rule;
    logic               sym;
    logic               r_halt;
    logic [1:0]         r_move;
    logic               r_wbit;
    logic [STATE_W-1:0] r_next;

    logic               left_fault;
    logic               right_fault;
    logic [STEP_W-1:0]  steps_inc;
    logic               launch;
    logic               step;
    logic               finish;
    logic [1:0]         fin_status;

    assign sym    = tape_q[head_q];
    assign r_halt = rule[RULE_HALT];
    assign r_move = rule[RULE_MOVE +: 2];
    assign r_wbit = rule[RULE_WBIT];
    assign r_next = rule[RULE_NEXT +: STATE_W];

    turing_rule_table #(
        .STATE_W(STATE_W)
    ) u_table (
        .clk  (clk),
        .rst  (rst),
        .we   (rule_we && (fsm_q != S_RUN)),
        .waddr(rule_addr),
        .wdata(rule_data),
        .raddr({state_q, sym}),
        .rdata(rule)
    );

    assign left_fault  = (r_move == MOVE_L) && (head_q == '0);
    assign right_fault = (r_move == MOVE_R) &&
                         (head_q == HEAD_W'(TAPE_LEN - 1));
    assign steps_inc   = steps_q + STEP_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q <= S_IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    always_comb begin
        fsm_d      = fsm_q;
        launch     = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        fin_status = ST_HALT;
        unique case (fsm_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    launch = 1'b1;
                    fsm_d  = S_RUN;
                end
            end
            S_RUN: begin
                if (r_halt) begin
                    finish = 1'b1;
                end else begin
                    step = 1'b1;
                    // Edge faults outrank the step-limit timeout
                    if (left_fault) begin
                        finish     = 1'b1;
                        fin_status = ST_LEFT;
                    end else if (right_fault) begin
                        finish     = 1'b1;
                        fin_status = ST_RIGHT;
                    end else if (steps_inc == STEP_W'(MAX_STEPS)) begin
                        finish     = 1'b1;
                        fin_status = ST_TIMEOUT;
                    end
                end
                if (finish) begin
                    fsm_d = S_DONE;
                end
            end
            default: fsm_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tape_q   <= '0;
            head_q   <= '0;
            state_q  <= '0;
            steps_q  <= '0;
            status_q <= ST_HALT;
        end else if (launch) begin
            tape_q   <= tape_in;
            head_q   <= head_in;
            state_q  <= '0;
            steps_q  <= '0;
            status_q <= ST_HALT;
        end else begin
            if (step) begin
                tape_q[head_q] <= r_wbit;
                state_q        <= r_next;
                steps_q        <= steps_inc;
                if (r_move == MOVE_R && !right_fault) begin
                    head_q <= head_q + HEAD_W'(1);
                end else if (r_move == MOVE_L && !left_fault) begin
                    head_q <= head_q - HEAD_W'(1);
                end
            end
            if (finish) begin
                status_q <= fin_status;
            end
        end
    end

    assign busy      = (fsm_q == S_RUN);
    assign done      = (fsm_q == S_DONE);
    assign status    = status_q;
    assign tape_out  = tape_q;
    assign head_out  = head_q;
    assign state_out = state_q;
    assign steps     = steps_q;

endmodule

// File: tb/tb_turing_engine.sv
// Scoreboard bench for turing_engine: stimulus queues expected run results,
// a monitor compares them whenever done rises.
module tb_turing_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        rule_we;
    logic [2:0]  rule_addr;
    logic [5:0]  rule_data;
    logic        start;
    logic [15:0] tape_in;
    logic [3:0]  head_in;
    logic        busy;
    logic        done;
    logic [1:0]  status;
    logic [15:0] tape_out;
    logic [3:0]  head_out;
    logic [1:0]  state_out;
    logic [7:0]  steps;

    typedef struct {
        logic [1:0]  status;
        logic [15:0] tape;
        logic [3:0]  head;
        logic [1:0]  st;
        logic [7:0]  steps;
        int          cycles;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   pass  = 0;

    localparam logic [1:0] R = 2'b01;
    localparam logic [1:0] L = 2'b10;
    localparam logic [1:0] S = 2'b00;

    turing_engine dut (
        .clk      (clk),
        .rst      (rst),
        .rule_we  (rule_we),
        .rule_addr(rule_addr),
        .rule_data(rule_data),
        .start    (start),
        .tape_in  (tape_in),
        .head_in  (head_in),
        .busy     (busy),
        .done     (done),
        .status   (status),
        .tape_out (tape_out),
        .head_out (head_out),
        .state_out(state_out),
        .steps    (steps)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [5:0] rule(input logic [1:0] ns, input logic w,
                                        input logic [1:0] mv, input logic h);
        return {ns, w, mv, h};
    endfunction

    // Monitor: count RUN cycles, compare on each rising done
    int   cnt = 0;
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            cnt = 0;
            prev_done = 1'b0;
        end else begin
            if (busy) cnt++;
            if (done && !prev_done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("status", 32'(status), 32'(e.status));
                    chk("tape", 32'(tape_out), 32'(e.tape));
                    chk("head", 32'(head_out), 32'(e.head));
                    chk("state", 32'(state_out), 32'(e.st));
                    chk("steps", 32'(steps), 32'(e.steps));
                    chk("run_cycles", 32'(cnt), 32'(e.cycles));
                end
                cnt = 0;
            end
            prev_done = done;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [5:0] d);
        rule_we = 1'b1;
        rule_addr = a;
        rule_data = d;
        tick();
        rule_we = 1'b0;
    endtask

    task automatic pulse_start(input logic [15:0] t, input logic [3:0] h);
        tape_in = t;
        head_in = h;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 1000) begin
            tick();
            n++;
        end
        if (!done) chk("done_timeout", 32'd0, 32'd1);
        tick();
    endtask

    task automatic check_zero();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_status", 32'(status), 32'd0);
        chk("rst_tape", 32'(tape_out), 32'd0);
        chk("rst_head", 32'(head_out), 32'd0);
        chk("rst_state", 32'(state_out), 32'd0);
        chk("rst_steps", 32'(steps), 32'd0);
    endtask

    task automatic prog_unary();
        wr(3'd0, rule(2'd0, 1'b0, R, 1'b0));
        wr(3'd1, rule(2'd1, 1'b1, R, 1'b0));
        wr(3'd2, rule(2'd2, 1'b1, R, 1'b0));
        wr(3'd3, rule(2'd1, 1'b1, R, 1'b0));
        wr(3'd4, rule(2'd3, 1'b0, L, 1'b0));
        wr(3'd5, rule(2'd2, 1'b1, R, 1'b0));
        wr(3'd6, rule(2'd0, 1'b0, S, 1'b1));
        wr(3'd7, rule(2'd0, 1'b0, S, 1'b0));
    endtask

    initial begin
        rst = 1'b1;
        rule_we = 1'b0;
        rule_addr = '0;
        rule_data = '0;
        start = 1'b0;
        tape_in = '0;
        head_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check_zero();
        rst = 1'b0;
        tick();

        // Unary-extend machine ends on the right edge
        prog_unary();
        q.push_back('{2'b10, 16'h01F0, 4'd15, 2'd0, 8'd19, 19});
        pulse_start(16'h03B0, 4'd0);
        wait_done();

        // Immediate halt
        wr(3'd0, rule(2'd0, 1'b0, S, 1'b1));
        q.push_back('{2'b00, 16'h1234, 4'd3, 2'd0, 8'd0, 1});
        pulse_start(16'h1234, 4'd3);
        wait_done();

        // Cleared table never halts: step timeout
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        q.push_back('{2'b11, 16'hFFFE, 4'd0, 2'd0, 8'd255, 255});
        pulse_start(16'hFFFF, 4'd0);
        wait_done();

        // Left move at cell 0
        wr(3'd0, rule(2'd0, 1'b1, L, 1'b0));
        q.push_back('{2'b01, 16'h0001, 4'd0, 2'd0, 8'd1, 1});
        pulse_start(16'h0000, 4'd0);
        wait_done();

        // rule_we and start during RUN are ignored
        prog_unary();
        q.push_back('{2'b10, 16'h01F0, 4'd15, 2'd0, 8'd19, 19});
        pulse_start(16'h03B0, 4'd0);
        tick();
        rule_we = 1'b1;
        rule_addr = 3'd0;
        rule_data = rule(2'd0, 1'b0, S, 1'b1);
        start = 1'b1;
        tape_in = 16'hFFFF;
        head_in = 4'd7;
        tick();
        rule_we = 1'b0;
        start = 1'b0;
        wait_done();

        // Table still intact from the ignored write
        q.push_back('{2'b10, 16'h01F0, 4'd15, 2'd0, 8'd19, 19});
        pulse_start(16'h03B0, 4'd0);
        wait_done();

        // Async reset mid-run
        pulse_start(16'h03B0, 4'd0);
        repeat (4) tick();
        chk("midrun_busy", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_zero();
        tick();
        rst = 1'b0;
        tick();
        q.push_back('{2'b11, 16'hFFFE, 4'd0, 2'd0, 8'd255, 255});
        pulse_start(16'hFFFF, 4'd0);
        wait_done();

        repeat (3) tick();
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule
